// File: rtl/jt7759_romcache_if.sv
// Bus bundle between jt7759 (byte ROM port) and the 16-bit memory request port.
// The cache sits on the slave modport; the ROM client plus memory form the master side.
interface jt7759_romcache_if;
  logic        rom_cs;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_ok;
  logic        mem_cs;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_ok;

  modport master (
    output rom_cs, rom_addr, mem_data, mem_ok,
    input  rom_data, rom_ok, mem_cs, mem_addr
  );

  modport slave (
    input  rom_cs, rom_addr, mem_data, mem_ok,
    output rom_data, rom_ok, mem_cs, mem_addr
  );
endinterface

// File: rtl/jt7759_romcache.sv
// Byte-to-word ROM fetch adapter: current-word cache plus optional sequential prefetch.
// Define JT7759_PREFETCH_EN to enable the prefetch entry and PREFETCH state.
module jt7759_romcache (
  input  logic              clk,
  input  logic              rst,
  jt7759_romcache_if.slave  bus
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch
`ifdef JT7759_PREFETCH_EN
    , StPrefetch
`endif
  } state_e;

  state_e      state_q;
  logic [15:0] cur_tag_q, cur_data_q;
  logic        cur_valid_q;
  logic        mem_cs_q;
  logic [15:0] mem_addr_q;

  logic [15:0] w;
  logic        cur_hit;

  assign w       = bus.rom_addr[16:1];
  assign cur_hit = cur_valid_q & (cur_tag_q == w);

  assign bus.rom_ok   = bus.rom_cs & cur_hit;
  assign bus.rom_data = bus.rom_addr[0] ? cur_data_q[15:8] : cur_data_q[7:0];
  assign bus.mem_cs   = mem_cs_q;
  assign bus.mem_addr = mem_addr_q;

`ifdef JT7759_PREFETCH_EN
  logic [15:0] pre_tag_q, pre_data_q;
  logic        pre_valid_q;
  logic        pre_hit;

  assign pre_hit = pre_valid_q & (pre_tag_q == w);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cur_tag_q   <= '0;
      cur_data_q  <= '0;
      cur_valid_q <= 1'b0;
      mem_cs_q    <= 1'b0;
      mem_addr_q  <= '0;
`ifdef JT7759_PREFETCH_EN
      pre_tag_q   <= '0;
      pre_data_q  <= '0;
      pre_valid_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.rom_cs && !cur_hit) begin
`ifdef JT7759_PREFETCH_EN
            if (pre_hit) begin
              // Promote the prefetched word; mem_cs stays low for the gap cycle.
              cur_tag_q   <= pre_tag_q;
              cur_data_q  <= pre_data_q;
              cur_valid_q <= 1'b1;
              pre_valid_q <= 1'b0;
              state_q     <= StPrefetch;
            end else
`endif
            begin
              mem_cs_q   <= 1'b1;
              mem_addr_q <= w;
              state_q    <= StFetch;
            end
          end
        end

        StFetch: begin
          if (bus.mem_ok) begin
            cur_tag_q   <= mem_addr_q;
            cur_data_q  <= bus.mem_data;
            cur_valid_q <= 1'b1;
            mem_cs_q    <= 1'b0;
`ifdef JT7759_PREFETCH_EN
            state_q     <= StPrefetch;
`else
            state_q     <= StIdle;
`endif
          end
        end

`ifdef JT7759_PREFETCH_EN
        StPrefetch: begin
          if (!mem_cs_q) begin
            mem_cs_q   <= 1'b1;
            mem_addr_q <= cur_tag_q + 16'd1;
          end else if (bus.mem_ok) begin
            mem_cs_q <= 1'b0;
            if (bus.rom_cs && (w == mem_addr_q)) begin
              // The in-flight word is the one now wanted: it becomes CUR and
              // prefetching continues from the word after it.
              cur_tag_q   <= mem_addr_q;
              cur_data_q  <= bus.mem_data;
              cur_valid_q <= 1'b1;
            end else begin
              pre_tag_q   <= mem_addr_q;
              pre_data_q  <= bus.mem_data;
              pre_valid_q <= 1'b1;
              state_q     <= StIdle;
            end
          end
        end
`endif

        default: begin
          mem_cs_q <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

endmodule
